// File: rtl/round_timer_ctrl_pkg.sv
// rtl/round_timer_ctrl_pkg.sv - shared state encoding, defaults and helpers for the round timer
package round_timer_ctrl_pkg;

  localparam int SECS_W = 4;

  localparam int DEFAULT_TICK_DIV   = 50000000;
  localparam int DEFAULT_START_SECS = 9;
  localparam int DEFAULT_WARN_SECS  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // A divide-by-one prescaler still needs a one-bit register to stay legal.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/round_timer_ctrl_if.sv
// rtl/round_timer_ctrl_if.sv - command and status bundle between game logic and the round timer
interface round_timer_ctrl_if;
  import round_timer_ctrl_pkg::*;

  logic              start;
  logic              abort;
  logic              pause;
  logic              load_valid;
  logic [SECS_W-1:0] load_secs;
  logic [SECS_W-1:0] secs_left;
  logic              running;
  logic              paused;
  logic              tick;
  logic              expired;
  logic              warn;

  modport master (
    output start, abort, pause, load_valid, load_secs,
    input  secs_left, running, paused, tick, expired, warn
  );

  modport slave (
    input  start, abort, pause, load_valid, load_secs,
    output secs_left, running, paused, tick, expired, warn
  );

endinterface

// File: rtl/round_timer_ctrl_tick_prescaler.sv
// rtl/round_timer_ctrl_tick_prescaler.sv - one-second prescaler with hold and synchronous clear
module tick_prescaler
  import round_timer_ctrl_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic terminal
);

  localparam int CW = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Combinational so the controller can register tick in the same edge it wraps.
  assign terminal = en && (cnt_q == LAST);

endmodule

// File: rtl/round_timer_ctrl.sv
// rtl/round_timer_ctrl.sv - commanded round countdown with pause, abort, restart and expiry pulse
module round_timer_ctrl
  import round_timer_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = DEFAULT_TICK_DIV,
  parameter int START_SECS = DEFAULT_START_SECS,
  parameter int WARN_SECS  = DEFAULT_WARN_SECS
) (
  input  logic          clk,
  input  logic          reset,
  round_timer_ctrl_if.slave bus
);

  localparam logic [SECS_W-1:0] START_V = SECS_W'(START_SECS);
  localparam logic [SECS_W-1:0] WARN_V  = SECS_W'(WARN_SECS);

  state_t            state_q, state_d;
  logic [SECS_W-1:0] preset_q, preset_d;
  logic [SECS_W-1:0] secs_q, secs_d;
  logic              tick_q, tick_d;
  logic              expired_q, expired_d;
  logic              running_q, running_d;
  logic              paused_q, paused_d;
  logic              warn_q, warn_d;
  logic              pre_en, pre_clr, terminal;

  // The prescaler advances on every RUN cycle, including the one that samples pause.
  assign pre_en = (state_q == ST_RUN);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (pre_en),
    .clr      (pre_clr),
    .terminal (terminal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      preset_q  <= START_V;
      secs_q    <= START_V;
      tick_q    <= 1'b0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      warn_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      preset_q  <= preset_d;
      secs_q    <= secs_d;
      tick_q    <= tick_d;
      expired_q <= expired_d;
      running_q <= running_d;
      paused_q  <= paused_d;
      warn_q    <= warn_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    preset_d  = preset_q;
    secs_d    = secs_q;
    tick_d    = 1'b0;
    expired_d = 1'b0;
    pre_clr   = 1'b0;

    if (bus.abort) begin
      state_d = ST_IDLE;
      pre_clr = 1'b1;
      secs_d  = preset_q;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // A coincident load lands before start so the run uses the new preset.
          if (bus.load_valid && (bus.load_secs != '0)) begin
            preset_d = bus.load_secs;
          end
          secs_d = preset_d;
          if (bus.start) begin
            state_d = ST_RUN;
            pre_clr = 1'b1;
          end
        end
        ST_RUN: begin
          if (terminal) begin
            tick_d = 1'b1;
            if (secs_q <= 4'd1) begin
              secs_d    = '0;
              expired_d = 1'b1;
              state_d   = ST_DONE;
            end else begin
              secs_d = secs_q - 1'b1;
            end
          end
          if (bus.pause && (state_d == ST_RUN)) begin
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (!bus.pause) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          secs_d = '0;
          if (bus.start) begin
            state_d = ST_RUN;
            pre_clr = 1'b1;
            secs_d  = preset_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          secs_d  = preset_q;
        end
      endcase
    end

    running_d = (state_d == ST_RUN);
    paused_d  = (state_d == ST_PAUSED);
    warn_d    = running_d && (secs_d <= WARN_V);
  end

  assign bus.secs_left = secs_q;
  assign bus.running   = running_q;
  assign bus.paused    = paused_q;
  assign bus.tick      = tick_q;
  assign bus.expired   = expired_q;
  assign bus.warn      = warn_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// tb/tb_round_timer_ctrl.sv - scoreboard bench for round_timer_ctrl against an elapsed-time model
module tb_round_timer_ctrl;

  localparam int TD = 4;
  localparam int SS = 3;
  localparam int WS = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  round_timer_ctrl_if bus();

  round_timer_ctrl #(.TICK_DIV(TD), .START_SECS(SS), .WARN_SECS(WS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int n_ticks = 0;
  int n_exp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a round is "preset seconds minus whole seconds of RUN time elapsed".
  typedef struct { int cyc; bit expd; int secs; } ev_t;
  ev_t q[$];
  int  cyc = 0;
  int  m_mode = 0;        // 0 idle, 1 counting, 2 frozen, 3 finished
  int  m_preset = SS;
  int  m_base = SS;
  int  m_elapsed = 0;

  function automatic int m_secs();
    if (m_mode == 0) return m_preset;
    if (m_mode == 3) return 0;
    return m_base - m_elapsed / TD;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_preset = SS; m_base = SS; m_elapsed = 0;
      q.delete();
    end else begin
      cyc++;
      if (bus.abort) begin
        m_mode = 0;
      end else begin
        case (m_mode)
          0: begin
            if (bus.load_valid && bus.load_secs != 0) m_preset = int'(bus.load_secs);
            if (bus.start) begin m_mode = 1; m_elapsed = 0; m_base = m_preset; end
          end
          1: begin
            m_elapsed++;
            if (m_elapsed % TD == 0) begin
              q.push_back('{cyc: cyc, expd: (m_secs() == 0), secs: m_secs()});
              if (m_secs() == 0) m_mode = 3;
              else if (bus.pause) m_mode = 2;
            end else if (bus.pause) begin
              m_mode = 2;
            end
          end
          2: if (!bus.pause) m_mode = 1;
          default: if (bus.start) begin m_mode = 1; m_elapsed = 0; m_base = m_preset; end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("secs_left", 32'(bus.secs_left), 32'(m_secs()));
      chk("running", 32'(bus.running), 32'(m_mode == 1));
      chk("paused", 32'(bus.paused), 32'(m_mode == 2));
      chk("warn", 32'(bus.warn), 32'(m_mode == 1 && m_secs() <= WS));
      if (bus.tick || bus.expired) begin
        if (bus.tick) n_ticks++;
        if (bus.expired) n_exp++;
        if (q.size() == 0 || q[0].cyc != cyc) begin
          chk("unexpected_pulse", 32'(bus.tick), 32'(0));
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("ev_tick", 32'(bus.tick), 32'(1));
          chk("ev_expired", 32'(bus.expired), 32'(e.expd));
          chk("ev_secs", 32'(bus.secs_left), 32'(e.secs));
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        void'(q.pop_front());
        chk("missed_tick", 32'(bus.tick), 32'(1));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; step(1); bus.start = 1'b0;
  endtask

  task automatic wait_expired(input int budget, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.expired) seen = 1'b1;
    end
    chk(nm, 32'(seen), 32'(1));
    step(1);
  endtask

  int t0, e0;

  initial begin
    bus.start = 0; bus.abort = 0; bus.pause = 0; bus.load_valid = 0; bus.load_secs = 0;
    #12;
    chk("rst_secs", 32'(bus.secs_left), 32'(SS));
    chk("rst_running", 32'(bus.running), 0);
    chk("rst_tick", 32'(bus.tick), 0);
    chk("rst_expired", 32'(bus.expired), 0);
    chk("rst_warn", 32'(bus.warn), 0);
    #10 reset = 1'b0;
    step(2);

    // basic countdown
    t0 = n_ticks; e0 = n_exp;
    pulse_start();
    wait_expired(40, "t1_expired_seen");
    chk("t1_tick_count", 32'(n_ticks - t0), 32'(3));
    chk("t1_exp_count", 32'(n_exp - e0), 32'(1));

    // load 5, then load 0 keeps 5
    bus.abort = 1; step(1); bus.abort = 0;
    bus.load_valid = 1; bus.load_secs = 4'd5; step(1); bus.load_valid = 0;
    chk("t2_loaded", 32'(bus.secs_left), 32'(5));
    t0 = n_ticks; pulse_start();
    wait_expired(60, "t2_expired_seen");
    chk("t2_tick_count", 32'(n_ticks - t0), 32'(5));
    bus.abort = 1; step(1); bus.abort = 0;
    bus.load_valid = 1; bus.load_secs = 4'd0; step(1); bus.load_valid = 0;
    chk("t2_zero_ignored", 32'(bus.secs_left), 32'(5));

    // pause mid-second
    bus.load_valid = 1; bus.load_secs = 4'd3; step(1); bus.load_valid = 0;
    pulse_start();
    step(2); bus.pause = 1; step(5);
    chk("t3_frozen_secs", 32'(bus.secs_left), 32'(3));
    chk("t3_paused", 32'(bus.paused), 32'(1));
    step(5); bus.pause = 0;
    wait_expired(40, "t3_expired_seen");

    // abort on the final terminal cycle
    bus.abort = 1; step(1); bus.abort = 0;
    e0 = n_exp; pulse_start();
    step(11); bus.abort = 1; step(1); bus.abort = 0;
    step(3);
    chk("t4_no_expired", 32'(n_exp - e0), 32'(0));
    chk("t4_idle_secs", 32'(bus.secs_left), 32'(3));

    // restart from DONE, start ignored in RUN
    pulse_start();
    wait_expired(40, "t5_first_done");
    pulse_start();
    step(2); pulse_start();
    wait_expired(40, "t5_restart_done");

    // asynchronous reset mid-run
    pulse_start();
    step(5);
    reset = 1'b1; #1;
    chk("t6_rst_secs", 32'(bus.secs_left), 32'(SS));
    chk("t6_rst_running", 32'(bus.running), 0);
    chk("t6_rst_tick", 32'(bus.tick), 0);
    chk("t6_rst_expired", 32'(bus.expired), 0);
    chk("t6_rst_warn", 32'(bus.warn), 0);
    @(negedge clk); #2 reset = 1'b0;
    step(2);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bus.start      = ($urandom_range(0, 7) == 0);
      bus.abort      = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0) bus.pause = ~bus.pause;
      bus.load_valid = ($urandom_range(0, 9) == 0);
      bus.load_secs  = 4'($urandom_range(0, 15));
      step(1);
    end
    bus.start = 0; bus.abort = 0; bus.pause = 0; bus.load_valid = 0;
    step(3);
    chk("queue_drained", 32'(q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end

endmodule
